// File: rtl/uart_pkg.sv
// uart_pkg: parity codes, tx FSM states (BREAK/BRK_REC only with UART_TX_BREAK_EN) and the baud divisor helper
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;
`ifdef UART_TX_BREAK_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BREAK, BRK_REC} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`endif
  function automatic int baud_div(input int clk_freq, input int baud_rate);
    return (clk_freq + baud_rate / 2) / baud_rate;
  endfunction
endpackage

// File: rtl/uart_tx_ex_fifo.sv
// uart_fifo: sync FIFO, ports clk, rst (async high), push/din in, pop/dout out, full, empty, level
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/uart_tx_ex.sv
// uart_tx_ex: framed UART TX with FIFO; clk, rst(async high), i_uart_data/i_uart_valid -> o_uart_ready, o_uart_tx, o_uart_busy, o_fifo_level; UART_TX_BREAK_EN adds i_uart_break
module uart_tx_ex
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_BITS-1:0]        i_uart_data,
  input  logic                        i_uart_valid,
`ifdef UART_TX_BREAK_EN
  input  logic                        i_uart_break,
`endif
  output logic                        o_uart_ready,
  output logic                        o_uart_tx,
  output logic                        o_uart_busy,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_level
);
  localparam int DIV = baud_div(CLK_FREQ, BAUD_RATE);
  localparam int CW = $clog2(DIV);
  state_t state;
  logic [CW-1:0] cnt;
  logic [3:0] bit_idx;
  logic [DATA_BITS-1:0] shreg, fifo_dout;
  logic par_bit, full, empty, pop, wrap, brk;
`ifdef UART_TX_BREAK_EN
  assign brk = i_uart_break;
`else
  assign brk = 1'b0;
`endif
  assign o_uart_ready = ~full;
  assign wrap = cnt == CW'(DIV - 1);
  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(i_uart_valid), .pop(pop), .din(i_uart_data),
    .dout(fifo_dout), .full(full), .empty(empty), .level(o_fifo_level)
  );
  // a frame (or break recovery) may chain straight into the next START on its final wrap
  always_comb begin
    pop = ~empty & ~brk & (state == IDLE || (state == STOP && wrap && bit_idx == 4'(STOP_BITS - 1)));
`ifdef UART_TX_BREAK_EN
    if (state == BRK_REC && wrap && !empty && !brk) pop = 1'b1;
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shreg <= '0;
      par_bit <= 1'b0;
      o_uart_tx <= 1'b1;
      o_uart_busy <= 1'b0;
    end else begin
      o_uart_busy <= state != IDLE || o_fifo_level != '0;
      cnt <= (wrap || state == IDLE) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: begin
`ifdef UART_TX_BREAK_EN
          if (brk) begin
            state <= BREAK;
            o_uart_tx <= 1'b0;
          end
`endif
        end
        START: if (wrap) begin
          state <= DATA;
          o_uart_tx <= shreg[0];
          shreg <= shreg >> 1;
          bit_idx <= '0;
        end
        DATA: if (wrap) begin
          if (bit_idx == 4'(DATA_BITS - 1)) begin
            state <= (PARITY != PAR_NONE) ? PAR : STOP;
            o_uart_tx <= (PARITY != PAR_NONE) ? par_bit : 1'b1;
            bit_idx <= '0;
          end else begin
            o_uart_tx <= shreg[0];
            shreg <= shreg >> 1;
            bit_idx <= bit_idx + 1'b1;
          end
        end
        PAR: if (wrap) begin
          state <= STOP;
          o_uart_tx <= 1'b1;
          bit_idx <= '0;
        end
        STOP: if (wrap) begin
          if (bit_idx == 4'(STOP_BITS - 1)) begin
`ifdef UART_TX_BREAK_EN
            state <= brk ? BREAK : IDLE;
            o_uart_tx <= ~brk;
`else
            state <= IDLE;
`endif
          end else bit_idx <= bit_idx + 1'b1;
        end
`ifdef UART_TX_BREAK_EN
        BREAK: begin
          cnt <= '0;
          if (!brk) begin
            state <= BRK_REC;
            o_uart_tx <= 1'b1;
          end
        end
        BRK_REC: if (wrap) begin
          state <= brk ? BREAK : IDLE;
          o_uart_tx <= ~brk;
        end
`endif
        default: state <= IDLE;
      endcase
      if (pop) begin
        state <= START;
        shreg <= fifo_dout;
        par_bit <= (PARITY == PAR_EVEN) ? ^fifo_dout : ~^fifo_dout;
        bit_idx <= '0;
        o_uart_tx <= 1'b0;
      end
    end
endmodule

// File: tb/tb_uart_tx_ex.sv
// tb_uart_tx_ex: directed + randomized bench comparing tx waveforms of four uart_tx_ex configurations to a bit-level frame model
module tb_uart_tx_ex;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic brk = 1'b0;
  logic [3:0] valid = '0;
  logic [3:0] ready, tx, busy;
  logic [3:0][8:0] din = '0;
  logic [3:0][2:0] lvl;
  int tests = 0;
  int fails = 0;
  int divs [4] = '{434, 434, 4, 4};
  int dbs [4] = '{8, 8, 8, 5};
  int pars [4] = '{0, 2, 1, 0};
  int stops [4] = '{1, 2, 2, 1};

  always #5 clk = ~clk;

  uart_tx_ex u0 (
    .clk(clk), .rst(rst), .i_uart_data(din[0][7:0]), .i_uart_valid(valid[0]),
`ifdef UART_TX_BREAK_EN
    .i_uart_break(brk),
`endif
    .o_uart_ready(ready[0]), .o_uart_tx(tx[0]), .o_uart_busy(busy[0]), .o_fifo_level(lvl[0])
  );
  uart_tx_ex #(.PARITY(2), .STOP_BITS(2)) u1 (
    .clk(clk), .rst(rst), .i_uart_data(din[1][7:0]), .i_uart_valid(valid[1]),
`ifdef UART_TX_BREAK_EN
    .i_uart_break(1'b0),
`endif
    .o_uart_ready(ready[1]), .o_uart_tx(tx[1]), .o_uart_busy(busy[1]), .o_fifo_level(lvl[1])
  );
  uart_tx_ex #(.CLK_FREQ(40), .BAUD_RATE(10), .PARITY(1), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .i_uart_data(din[2][7:0]), .i_uart_valid(valid[2]),
`ifdef UART_TX_BREAK_EN
    .i_uart_break(1'b0),
`endif
    .o_uart_ready(ready[2]), .o_uart_tx(tx[2]), .o_uart_busy(busy[2]), .o_fifo_level(lvl[2])
  );
  uart_tx_ex #(.CLK_FREQ(40), .BAUD_RATE(10), .DATA_BITS(5)) u3 (
    .clk(clk), .rst(rst), .i_uart_data(din[3][4:0]), .i_uart_valid(valid[3]),
`ifdef UART_TX_BREAK_EN
    .i_uart_break(1'b0),
`endif
    .o_uart_ready(ready[3]), .o_uart_tx(tx[3]), .o_uart_busy(busy[3]), .o_fifo_level(lvl[3])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int flen(input int k);
    return divs[k] * (1 + dbs[k] + int'(pars[k] != 0) + stops[k]);
  endfunction

  // line level at cycle c of a frame: start 0, data LSB first, optional parity, stop 1
  function automatic logic exp_bit(input int k, input int w, input int c);
    int b;
    int d;
    b = c / divs[k];
    d = w & ((1 << dbs[k]) - 1);
    if (b == 0) return 1'b0;
    b = b - 1;
    if (b < dbs[k]) return d[b];
    b = b - dbs[k];
    if (pars[k] != 0 && b == 0) return (pars[k] == 2) ? ^d : ~^d;
    return 1'b1;
  endfunction

  task automatic wait_fall(input int k, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++)
      if (tx[k] === 1'b0) ok = 1'b1;
      else tick();
    chk($sformatf("u%0d_start_seen", k), 32'(ok), 1);
  endtask

  task automatic send_words(input int k, input int words[$]);
    foreach (words[j]) begin
      for (int i = 0; i < 60000 && ready[k] !== 1'b1; i++) tick();
      if (ready[k] !== 1'b1) begin
        chk($sformatf("u%0d_ready_timeout", k), 32'(ready[k]), 1);
        return;
      end
      valid[k] = 1'b1;
      din[k] = 9'(words[j]);
      tick();
      valid[k] = 1'b0;
    end
  endtask

  task automatic expect_stream(input int k, input int words[$], input bit gapless);
    bit ok;
    int bad;
    logic got, want;
    ok = 1'b1;
    foreach (words[j]) begin
      bad = -1;
      got = 1'b1;
      want = 1'b1;
      if (j == 0 || !gapless) wait_fall(k, 20000, ok);
      if (!ok) return;
      for (int c = 0; c < flen(k); c++) begin
        if (bad < 0 && tx[k] !== exp_bit(k, words[j], c)) begin
          bad = c;
          got = tx[k];
          want = exp_bit(k, words[j], c);
        end
        tick();
      end
      chk($sformatf("u%0d_frame%0d_w%0h_cyc%0d", k, j, words[j], bad), 32'(got), 32'(want));
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int q[$];
    int w[6];
    int exp_lvl[6] = '{1, 1, 2, 3, 4, 4};
    int lows;
    bit ok;
    logic got, want;
    int bad;
    repeat (3) tick();
    chk("rst_tx", 32'(tx[0]), 1);
    chk("rst_busy", 32'(busy[0]), 0);
    chk("rst_ready", 32'(ready[0]), 1);
    chk("rst_level", 32'(lvl[0]), 0);
    rst = 1'b0;
    tick();
    // single 0xA5 with latency and busy timing
    din[0] = 9'h0A5;
    valid[0] = 1'b1;
    tick();
    valid[0] = 1'b0;
    chk("lat_level_n", 32'(lvl[0]), 1);
    chk("lat_tx_n", 32'(tx[0]), 1);
    chk("lat_busy_n", 32'(busy[0]), 0);
    tick();
    chk("lat_tx_n1", 32'(tx[0]), 0);
    chk("lat_busy_n1", 32'(busy[0]), 1);
    q = {32'hA5};
    expect_stream(0, q, 1'b0);
    chk("a5_idle_tx", 32'(tx[0]), 1);
    chk("a5_busy_last", 32'(busy[0]), 1);
    tick();
    chk("a5_busy_fall", 32'(busy[0]), 0);
    // parity / two stop bits
    q = {32'h07};
    send_words(1, q);
    expect_stream(1, q, 1'b0);
    chk("u1_idle_after", 32'(tx[1]), 1);
    send_words(2, q);
    expect_stream(2, q, 1'b0);
    chk("u2_idle_after", 32'(tx[2]), 1);
    // five-bit back-to-back
    q = {32'h1F, 32'h00};
    fork
      send_words(3, q);
      expect_stream(3, q, 1'b1);
    join
    chk("u3_idle_after", 32'(tx[3]), 1);
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(int'($urandom_range(0, 511)));
    fork
      send_words(3, q);
      expect_stream(3, q, 1'b1);
    join
    chk("u3_rand_idle", 32'(tx[3]), 1);
    q = {};
    for (int i = 0; i < 8; i++) q.push_back(int'($urandom_range(0, 255)));
    fork
      send_words(2, q);
      expect_stream(2, q, 1'b1);
    join
    chk("u2_rand_idle", 32'(tx[2]), 1);
    // FIFO fill: valid held 6 cycles from empty
    for (int i = 0; i < 6; i++) w[i] = int'($urandom_range(0, 255));
    q = {w[0], w[1], w[2], w[3], w[4]};
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          valid[0] = 1'b1;
          din[0] = 9'(w[i]);
          chk($sformatf("fill_ready%0d", i), 32'(ready[0]), (i < 5) ? 1 : 0);
          tick();
          chk($sformatf("fill_level%0d", i), 32'(lvl[0]), 32'(exp_lvl[i]));
        end
        valid[0] = 1'b0;
      end
      expect_stream(0, q, 1'b1);
    join
    chk("fill_idle_tx", 32'(tx[0]), 1);
    chk("fill_level_end", 32'(lvl[0]), 0);
`ifdef UART_TX_BREAK_EN
    // break raised 100 clocks into a 0x55 frame for 5000 clocks, 0x3C queued
    q = {32'h55, 32'h3C};
    send_words(0, q);
    wait_fall(0, 100, ok);
    bad = -1;
    got = 1'b1;
    want = 1'b1;
    for (int c = 0; c < 5535 + 4340; c++) begin
      if (c == 100) brk = 1'b1;
      if (c == 5100) brk = 1'b0;
      if (c == 4500) chk("brk_busy", 32'(busy[0]), 1);
      if (bad < 0 && tx[0] !== (c < 4340 ? exp_bit(0, 'h55, c) : c < 5101 ? 1'b0 :
                                c < 5535 ? 1'b1 : exp_bit(0, 'h3C, c - 5535))) begin
        bad = c;
        got = tx[0];
        want = c < 4340 ? exp_bit(0, 'h55, c) : c < 5101 ? 1'b0 : c < 5535 ? 1'b1 : exp_bit(0, 'h3C, c - 5535);
      end
      tick();
    end
    chk($sformatf("brk_wave_cyc%0d", bad), 32'(got), 32'(want));
    chk("brk_idle_tx", 32'(tx[0]), 1);
`endif
    // async reset in the middle of data bit 0 (a zero) of 0x66
    q = {32'h66};
    send_words(0, q);
    wait_fall(0, 100, ok);
    repeat (634) tick();
    chk("pre_rst_tx", 32'(tx[0]), 0);
    chk("pre_rst_busy", 32'(busy[0]), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_tx", 32'(tx[0]), 1);
    chk("rst_mid_level", 32'(lvl[0]), 0);
    chk("rst_mid_busy", 32'(busy[0]), 0);
    chk("rst_mid_ready", 32'(ready[0]), 1);
    tick();
    rst = 1'b0;
    lows = 0;
    for (int c = 0; c < 3000; c++) begin
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0) lows++;
      tick();
    end
    chk("post_rst_quiet", 32'(lows), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
